// File: rtl/dispatch_sched_pkg.sv
// Shared definitions for the dispatch scheduler: reservation-station class
// encoding, RS count, rsop field width and the op-class decode rule.
package dispatch_sched_pkg;

    localparam int NUM_RS = 4;
    localparam int RSOP_W = 5;

    typedef logic [1:0] rs_class_t;

    localparam rs_class_t RS_ALU = 2'd0;
    localparam rs_class_t RS_BR  = 2'd1;
    localparam rs_class_t RS_MEM = 2'd2;
    localparam rs_class_t RS_MUL = 2'd3;

    // Memory ops win over everything, then the mul/div opcode group
    // (top two rsop bits set), then branches (JALR included), else ALU.
    function automatic rs_class_t decode_class(
        input logic       uses_mem,
        input logic [1:0] rsop_hi,
        input logic       branch
    );
        rs_class_t cls;
        if (uses_mem)
            cls = RS_MEM;
        else if (rsop_hi == 2'b11)
            cls = RS_MUL;
        else if (branch)
            cls = RS_BR;
        else
            cls = RS_ALU;
        return cls;
    endfunction

endpackage

// File: rtl/dispatch_sched_credit.sv
// Per-reservation-station credit counter. Starts full (DEPTH free entries),
// drops by one on each dispatch into the RS and rises by one on each entry
// the RS frees. Flush and reset both refill to DEPTH because the RS empties
// itself on a flush.
module rs_credit_ctr
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic take,
    input  logic ret,
    output logic avail
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    // Refuse to elaborate when the counter cannot represent a full RS.
    generate
        if (DEPTH < 1 || DEPTH > (2 ** CNT_W) - 1) begin : g_bad_cnt_w
            $error("rs_credit_ctr: CNT_W=%0d cannot hold DEPTH=%0d", CNT_W, DEPTH);
        end
    endgenerate

    logic [CNT_W-1:0] r_cnt_p0;

    // A return while already full is a protocol error upstream; hold at FULL.
    function automatic logic [CNT_W-1:0] inc_sat(input logic [CNT_W-1:0] c);
        return (c == FULL) ? c : c + 1'b1;
    endfunction

    // Dispatch is only ever issued with credit available; floor at zero anyway.
    function automatic logic [CNT_W-1:0] dec_floor(input logic [CNT_W-1:0] c);
        return (c == '0) ? c : c - 1'b1;
    endfunction

    // Credit update: a take and a return in the same cycle cancel out.
    always_ff @(posedge clk) begin
        if (rst || flush)
            r_cnt_p0 <= FULL;
        else if (take && !ret)
            r_cnt_p0 <= dec_floor(r_cnt_p0);
        else if (ret && !take)
            r_cnt_p0 <= inc_sat(r_cnt_p0);
    end

    // Flag a credit return that would overflow a full counter.
    always_ff @(posedge clk) begin
        if (!rst && !flush && ret && !take) begin
            assert (r_cnt_p0 != FULL)
                else $warning("rs_credit_ctr: credit returned while already at DEPTH=%0d", DEPTH);
        end
    end

    assign avail = (r_cnt_p0 != '0);

endmodule

// File: rtl/dispatch_sched.sv
// Dispatch scheduler: holds one renamed micro-op and steers it to the ALU,
// BR, MEM or MUL reservation station when that station has a free entry.
// Rename is stalled while the held op is waiting on credit. A ROB flush
// drops the held op and refills every credit counter.
module dispatch_sched
    import dispatch_sched_pkg::*;
#(
    parameter int PAYLOAD_W = 64,
    parameter int ALU_DEPTH = 8,
    parameter int BR_DEPTH  = 4,
    parameter int MEM_DEPTH = 8,
    parameter int MUL_DEPTH = 2,
    parameter int CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rob_flush,
    input  logic                 in_valid,
    input  logic [RSOP_W-1:0]    in_rsop,
    input  logic                 in_uses_memory,
    input  logic                 in_branch,
    input  logic [7:0]           in_robid,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 dispatch_stall,
    output logic [NUM_RS-1:0]    rs_valid,
    output logic [RSOP_W-1:0]    rs_rsop,
    output logic [7:0]           rs_robid,
    output logic [PAYLOAD_W-1:0] rs_payload,
    input  logic [NUM_RS-1:0]    rs_credit_ret
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_HOLD = 1'b1;

    logic                 r_state_p0;
    rs_class_t            r_cls_p0;
    logic [RSOP_W-1:0]    r_rsop_p0;
    logic [7:0]           r_robid_p0;
    logic [PAYLOAD_W-1:0] r_payload_p0;

    logic [NUM_RS-1:0]    w_avail;
    logic [NUM_RS-1:0]    w_take;
    logic                 w_held;
    logic                 w_can_fire;
    logic                 w_fire;
    logic                 w_accept;
    rs_class_t            w_in_cls;

    // Fire/stall/accept decisions; everything reaching rs_valid comes from
    // registered state, with flush and reset only able to suppress a dispatch.
    always_comb begin
        w_held         = (r_state_p0 == ST_HOLD);
        w_can_fire     = w_held & w_avail[r_cls_p0];
        w_fire         = w_can_fire & ~rob_flush & ~rst;
        dispatch_stall = w_held & ~w_can_fire;
        w_accept       = in_valid & ~dispatch_stall & ~rob_flush;
        w_in_cls       = decode_class(in_uses_memory, in_rsop[RSOP_W-1 -: 2], in_branch);
        w_take         = '0;
        if (w_fire)
            w_take[r_cls_p0] = 1'b1;
        rs_valid       = w_take;
    end

    // IDLE/HOLD control: flush empties the slot, accept fills it (even when
    // the current occupant leaves this cycle), a lone dispatch empties it.
    always_ff @(posedge clk) begin
        if (rst)
            r_state_p0 <= ST_IDLE;
        else if (rob_flush)
            r_state_p0 <= ST_IDLE;
        else if (w_accept)
            r_state_p0 <= ST_HOLD;
        else if (w_fire)
            r_state_p0 <= ST_IDLE;
    end

    // Held op contents; only meaningful while the slot is occupied.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_cls_p0     <= w_in_cls;
            r_rsop_p0    <= in_rsop;
            r_robid_p0   <= in_robid;
            r_payload_p0 <= in_payload;
        end
    end

    assign rs_rsop    = r_rsop_p0;
    assign rs_robid   = r_robid_p0;
    assign rs_payload = r_payload_p0;

    rs_credit_ctr #(.DEPTH(ALU_DEPTH), .CNT_W(CNT_W)) u_cred_alu (
        .clk   (clk),
        .rst   (rst),
        .flush (rob_flush),
        .take  (w_take[RS_ALU]),
        .ret   (rs_credit_ret[RS_ALU]),
        .avail (w_avail[RS_ALU])
    );

    rs_credit_ctr #(.DEPTH(BR_DEPTH), .CNT_W(CNT_W)) u_cred_br (
        .clk   (clk),
        .rst   (rst),
        .flush (rob_flush),
        .take  (w_take[RS_BR]),
        .ret   (rs_credit_ret[RS_BR]),
        .avail (w_avail[RS_BR])
    );

    rs_credit_ctr #(.DEPTH(MEM_DEPTH), .CNT_W(CNT_W)) u_cred_mem (
        .clk   (clk),
        .rst   (rst),
        .flush (rob_flush),
        .take  (w_take[RS_MEM]),
        .ret   (rs_credit_ret[RS_MEM]),
        .avail (w_avail[RS_MEM])
    );

    rs_credit_ctr #(.DEPTH(MUL_DEPTH), .CNT_W(CNT_W)) u_cred_mul (
        .clk   (clk),
        .rst   (rst),
        .flush (rob_flush),
        .take  (w_take[RS_MUL]),
        .ret   (rs_credit_ret[RS_MUL]),
        .avail (w_avail[RS_MUL])
    );

endmodule

// File: tb/tb_dispatch_sched.sv
// Testbench for dispatch_sched: directed vector table, hand-written
// multi-cycle sequences, and a randomized run against a queue/array model.
module tb_dispatch_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rob_flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [4:0]  in_rsop = '0;
    logic        in_uses_memory = 1'b0;
    logic        in_branch = 1'b0;
    logic [7:0]  in_robid = '0;
    logic [63:0] in_payload = '0;
    logic        dispatch_stall;
    logic [3:0]  rs_valid;
    logic [4:0]  rs_rsop;
    logic [7:0]  rs_robid;
    logic [63:0] rs_payload;
    logic [3:0]  rs_credit_ret = '0;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dispatch_sched dut (
        .clk            (clk),
        .rst            (rst),
        .rob_flush      (rob_flush),
        .in_valid       (in_valid),
        .in_rsop        (in_rsop),
        .in_uses_memory (in_uses_memory),
        .in_branch      (in_branch),
        .in_robid       (in_robid),
        .in_payload     (in_payload),
        .dispatch_stall (dispatch_stall),
        .rs_valid       (rs_valid),
        .rs_rsop        (rs_rsop),
        .rs_robid       (rs_robid),
        .rs_payload     (rs_payload),
        .rs_credit_ret  (rs_credit_ret)
    );

    typedef struct packed {
        logic       v;
        logic [4:0] op;
        logic       mem;
        logic       br;
        logic [7:0] id;
        logic [3:0] ev;
        logic       es;
        logic [7:0] eid;
        logic [4:0] eop;
    } vec_t;

    typedef struct {
        int          cls;
        logic [4:0]  op;
        logic [7:0]  id;
        logic [63:0] pl;
    } mop_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string nm, input logic [3:0] ev, input logic es,
                           input bit do_es, input logic [7:0] eid, input logic [4:0] eop);
        chk({nm, ".rs_valid"}, 64'(rs_valid), 64'(ev));
        if (do_es) chk({nm, ".stall"}, 64'(dispatch_stall), 64'(es));
        if (ev != 4'b0) begin
            chk({nm, ".robid"}, 64'(rs_robid), 64'(eid));
            chk({nm, ".rsop"}, 64'(rs_rsop), 64'(eop));
            chk({nm, ".payload"}, rs_payload, {8{eid}});
        end
    endtask

    // Drive one cycle of inputs just after the edge, return at the falling edge.
    task automatic apply(input logic r, input logic v, input logic [4:0] op,
                         input logic mem, input logic br, input logic [7:0] id,
                         input logic fl, input logic [3:0] ret);
        @(posedge clk); #1;
        rst = r; in_valid = v; in_rsop = op; in_uses_memory = mem; in_branch = br;
        in_robid = id; in_payload = {8{id}}; rob_flush = fl; rs_credit_ret = ret;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0; rob_flush = 1'b0; rs_credit_ret = '0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset.rs_valid", 64'(rs_valid), 64'd0);
        chk("reset.stall", 64'(dispatch_stall), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    function automatic int model_class(input logic mem, input logic [4:0] op, input logic br);
        if (mem) return 2;
        if (op[4] && op[3]) return 3;
        if (br) return 1;
        return 0;
    endfunction

    task automatic run_random(input int ncyc);
        mop_t        hold_q[$];
        mop_t        m;
        int          cred[4];
        int          depth[4];
        logic        v, mem, br, fl, can, fire, estall;
        logic [4:0]  op;
        logic [7:0]  id;
        logic [63:0] pl;
        logic [3:0]  ret, ev;
        depth = '{8, 4, 8, 2};
        cred = depth;
        do_reset();
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk); #1;
            v   = ($urandom_range(0, 99) < 70);
            op  = 5'($urandom);
            mem = ($urandom_range(0, 3) == 0);
            br  = ($urandom_range(0, 2) == 0);
            id  = 8'($urandom);
            pl  = {$urandom, $urandom};
            fl  = ($urandom_range(0, 49) == 0);
            ret = '0;
            for (int i = 0; i < 4; i++)
                if (cred[i] < depth[i] && $urandom_range(0, 3) == 0) ret[i] = 1'b1;
            in_valid = v; in_rsop = op; in_uses_memory = mem; in_branch = br;
            in_robid = id; in_payload = pl; rob_flush = fl; rs_credit_ret = ret;
            @(negedge clk);
            can    = (hold_q.size() > 0) && (cred[hold_q[0].cls] > 0);
            fire   = can && !fl;
            estall = (hold_q.size() > 0) && !can;
            ev     = fire ? 4'(1 << hold_q[0].cls) : 4'b0;
            chk("rnd.rs_valid", 64'(rs_valid), 64'(ev));
            if (!fl) chk("rnd.stall", 64'(dispatch_stall), 64'(estall));
            if (fire) begin
                chk("rnd.robid", 64'(rs_robid), 64'(hold_q[0].id));
                chk("rnd.rsop", 64'(rs_rsop), 64'(hold_q[0].op));
                chk("rnd.payload", rs_payload, hold_q[0].pl);
            end
            if (fl) begin
                hold_q.delete();
                cred = depth;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (ret[i]) cred[i]++;
                    if (fire && hold_q[0].cls == i) cred[i]--;
                    if (cred[i] > depth[i]) cred[i] = depth[i];
                end
                if (fire) void'(hold_q.pop_front());
                if (v && !estall) begin
                    m.cls = model_class(mem, op, br);
                    m.op = op; m.id = id; m.pl = pl;
                    hold_q.push_back(m);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tv[9];
        // Priority decode and back-to-back steering, one RS per cycle.
        tv[0] = '{1'b1, 5'b01010, 1'b1, 1'b0, 8'd20, 4'b0000, 1'b0, 8'd0,  5'b00000};
        tv[1] = '{1'b1, 5'b11000, 1'b0, 1'b0, 8'd21, 4'b0100, 1'b0, 8'd20, 5'b01010};
        tv[2] = '{1'b1, 5'b10000, 1'b0, 1'b1, 8'd22, 4'b1000, 1'b0, 8'd21, 5'b11000};
        tv[3] = '{1'b1, 5'b00000, 1'b0, 1'b0, 8'd23, 4'b0010, 1'b0, 8'd22, 5'b10000};
        tv[4] = '{1'b1, 5'b11001, 1'b1, 1'b0, 8'd24, 4'b0001, 1'b0, 8'd23, 5'b00000};
        tv[5] = '{1'b1, 5'b11011, 1'b0, 1'b1, 8'd25, 4'b0100, 1'b0, 8'd24, 5'b11001};
        tv[6] = '{1'b1, 5'b00111, 1'b0, 1'b1, 8'd26, 4'b1000, 1'b0, 8'd25, 5'b11011};
        tv[7] = '{1'b0, 5'b00000, 1'b0, 1'b0, 8'd0,  4'b0010, 1'b0, 8'd26, 5'b00111};
        tv[8] = '{1'b0, 5'b00000, 1'b0, 1'b0, 8'd0,  4'b0000, 1'b0, 8'd0,  5'b00000};

        // Nine ALU ops, eight credits, then one return releases the ninth.
        do_reset();
        for (int c = 0; c < 9; c++) begin
            apply(0, 1, 5'b00000, 0, 0, 8'(c), 0, 4'b0000);
            chk_out("t1.fire", (c == 0) ? 4'b0000 : 4'b0001, 1'b0, 1, 8'(c - 1), 5'b00000);
        end
        apply(0, 0, 5'b00000, 0, 0, 8'd0, 0, 4'b0000);
        chk_out("t1.stall", 4'b0000, 1'b1, 1, 8'd0, 5'b0);
        apply(0, 0, 5'b00000, 0, 0, 8'd0, 0, 4'b0001);
        chk_out("t1.ret", 4'b0000, 1'b1, 1, 8'd0, 5'b0);
        apply(0, 0, 5'b00000, 0, 0, 8'd0, 0, 4'b0000);
        chk_out("t1.release", 4'b0001, 1'b0, 1, 8'd8, 5'b00000);

        do_reset();
        for (int i = 0; i < 9; i++) begin
            apply(0, tv[i].v, tv[i].op, tv[i].mem, tv[i].br, tv[i].id, 0, 4'b0000);
            chk_out($sformatf("t2[%0d]", i), tv[i].ev, tv[i].es, 1, tv[i].eid, tv[i].eop);
        end

        // MUL at zero credit with a same-cycle return and a waiting new op.
        do_reset();
        apply(0, 1, 5'b11000, 0, 0, 8'd30, 0, 4'b0000); chk_out("t3.c0", 4'b0000, 0, 1, 8'd0, 5'b0);
        apply(0, 1, 5'b11000, 0, 0, 8'd31, 0, 4'b0000); chk_out("t3.c1", 4'b1000, 0, 1, 8'd30, 5'b11000);
        apply(0, 1, 5'b11000, 0, 0, 8'd32, 0, 4'b0000); chk_out("t3.c2", 4'b1000, 0, 1, 8'd31, 5'b11000);
        apply(0, 1, 5'b00000, 0, 0, 8'd33, 0, 4'b1000); chk_out("t3.c3", 4'b0000, 1, 1, 8'd0, 5'b0);
        apply(0, 1, 5'b00000, 0, 0, 8'd33, 0, 4'b0000); chk_out("t3.c4", 4'b1000, 0, 1, 8'd32, 5'b11000);
        apply(0, 1, 5'b11000, 0, 0, 8'd34, 0, 4'b0000); chk_out("t3.c5", 4'b0001, 0, 1, 8'd33, 5'b00000);
        apply(0, 0, 5'b00000, 0, 0, 8'd0,  0, 4'b0000); chk_out("t3.c6", 4'b0000, 1, 1, 8'd0, 5'b0);

        // Flush while a BR op is stalled: op dropped, credits refilled.
        do_reset();
        apply(0, 1, 5'b11000, 0, 0, 8'd40, 0, 4'b0000);
        apply(0, 1, 5'b11000, 0, 0, 8'd41, 0, 4'b0000); chk_out("t4.mul0", 4'b1000, 0, 1, 8'd40, 5'b11000);
        for (int c = 0; c < 5; c++) begin
            apply(0, 1, 5'b00101, 0, 1, 8'(42 + c), 0, 4'b0000);
            if (c == 0) chk_out("t4.mul1", 4'b1000, 0, 1, 8'd41, 5'b11000);
            else        chk_out("t4.br", 4'b0010, 0, 1, 8'(41 + c), 5'b00101);
        end
        apply(0, 0, 5'b00000, 0, 0, 8'd0,  0, 4'b0000); chk_out("t4.stall", 4'b0000, 1, 1, 8'd0, 5'b0);
        apply(0, 1, 5'b00000, 0, 0, 8'd47, 1, 4'b0000); chk_out("t4.flush", 4'b0000, 0, 0, 8'd0, 5'b0);
        apply(0, 1, 5'b00101, 0, 1, 8'd48, 0, 4'b0000); chk_out("t4.after", 4'b0000, 0, 1, 8'd0, 5'b0);
        apply(0, 1, 5'b11000, 0, 0, 8'd49, 0, 4'b0000); chk_out("t4.br", 4'b0010, 0, 1, 8'd48, 5'b00101);
        apply(0, 1, 5'b11000, 0, 0, 8'd50, 0, 4'b0000); chk_out("t4.mulA", 4'b1000, 0, 1, 8'd49, 5'b11000);
        apply(0, 0, 5'b00000, 0, 0, 8'd0,  0, 4'b0000); chk_out("t4.mulB", 4'b1000, 0, 1, 8'd50, 5'b11000);
        apply(0, 0, 5'b00000, 0, 0, 8'd0,  0, 4'b0000); chk_out("t4.idle", 4'b0000, 0, 1, 8'd0, 5'b0);

        // Fire and return to BR in one cycle at credit 3, then count it down.
        do_reset();
        apply(0, 1, 5'b00101, 0, 1, 8'd60, 0, 4'b0000); chk_out("t5.c0", 4'b0000, 0, 1, 8'd0, 5'b0);
        for (int c = 1; c <= 5; c++) begin
            apply(0, 1, 5'b00101, 0, 1, 8'(60 + c), 0, (c == 2) ? 4'b0010 : 4'b0000);
            chk_out("t5.br", 4'b0010, 0, 1, 8'(59 + c), 5'b00101);
        end
        apply(0, 0, 5'b00000, 0, 0, 8'd0, 0, 4'b0000); chk_out("t5.stall", 4'b0000, 1, 1, 8'd0, 5'b0);

        // Return at full ALU credit must not grow past DEPTH.
        do_reset();
        apply(0, 0, 5'b00000, 0, 0, 8'd0, 0, 4'b0001);
        for (int c = 0; c < 9; c++) begin
            apply(0, 1, 5'b00000, 0, 0, 8'(70 + c), 0, 4'b0000);
            chk_out("t5.sat", (c == 0) ? 4'b0000 : 4'b0001, 0, 1, 8'(69 + c), 5'b00000);
        end
        apply(0, 0, 5'b00000, 0, 0, 8'd0, 0, 4'b0000); chk_out("t5.satstall", 4'b0000, 1, 1, 8'd0, 5'b0);

        // Reset together with flush while an op is held.
        do_reset();
        apply(0, 1, 5'b11000, 0, 0, 8'd80, 0, 4'b0000);
        apply(0, 1, 5'b11000, 0, 0, 8'd81, 0, 4'b0000);
        apply(0, 1, 5'b11000, 0, 0, 8'd82, 0, 4'b0000);
        apply(0, 0, 5'b00000, 0, 0, 8'd0,  0, 4'b0000); chk_out("t6.held", 4'b0000, 1, 1, 8'd0, 5'b0);
        apply(1, 1, 5'b00000, 0, 0, 8'd83, 1, 4'b0000); chk_out("t6.rst", 4'b0000, 0, 0, 8'd0, 5'b0);
        apply(0, 0, 5'b00000, 0, 0, 8'd0,  0, 4'b0000); chk_out("t6.post", 4'b0000, 0, 1, 8'd0, 5'b0);
        apply(0, 1, 5'b11000, 0, 0, 8'd84, 0, 4'b0000);
        apply(0, 1, 5'b11000, 0, 0, 8'd85, 0, 4'b0000); chk_out("t6.mulA", 4'b1000, 0, 1, 8'd84, 5'b11000);
        apply(0, 0, 5'b00000, 0, 0, 8'd0,  0, 4'b0000); chk_out("t6.mulB", 4'b1000, 0, 1, 8'd85, 5'b11000);
        apply(0, 0, 5'b00000, 0, 0, 8'd0,  0, 4'b0000); chk_out("t6.idle", 4'b0000, 0, 1, 8'd0, 5'b0);

        run_random(1500);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
